status_reg_writer: RTL and testbench

Producer side of the NZCV status interface that the condition checker consumes. Derives N/Z/C/V from the execute-stage ALU result when an S-bit instruction executes, holds them in a one-deep pending stage, and commits them to the architectural status register one cycle later. Drives the packed status bus used by the ID-stage condition check and raises a hazard while a flag write is in flight.

---
 rtl/status_reg_writer.sv | 87 ++++++++
 tb/tb_status_reg_writer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/status_reg_writer.sv
// NZCV producer: derives flags in EXE, holds them one cycle pending, then commits them.
// Optional STAT_BYPASS_EN forwards the pending flags to stat_out and ties flags_pending low.
`ifndef STATUS_REG_LEN
`define STATUS_REG_LEN 4
`endif

module status_reg_writer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        freeze,
  input  logic                        flush,
  input  logic                        exe_valid,
  input  logic                        s_bit,
  input  logic                        flag_arith,
  input  logic [DATA_W-1:0]           alu_res,
  input  logic                        alu_cout,
  input  logic                        alu_ovf,
  output logic [`STATUS_REG_LEN-1:0]  stat_out,
  output logic                        flags_pending,
  output logic [CNT_W-1:0]            commit_cnt
);

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic signed [DATA_W-1:0] res_s_p0;
  logic [3:0]               flags_p0;
  logic                     capture_p0;
  logic [3:0]               latest;
  logic [3:0]               pend_flags_p1;
  logic                     pend_vld_p1;
  logic [3:0]               arch_flags_p2;
  logic [CNT_W-1:0]         cnt_p2;

  // EXE: flag derivation; logical ops carry C/V forward from the newest flags
  always_comb begin
    res_s_p0           = alu_res;
    latest             = pend_vld_p1 ? pend_flags_p1 : arch_flags_p2;
    flags_p0           = '0;
    flags_p0[FLAG_Z]   = (res_s_p0 == '0);
    flags_p0[FLAG_N]   = (res_s_p0 < 0);
    flags_p0[FLAG_C]   = flag_arith ? alu_cout : latest[FLAG_C];
    flags_p0[FLAG_V]   = flag_arith ? alu_ovf  : latest[FLAG_V];
    capture_p0         = exe_valid & s_bit & ~flush & ~freeze;
  end

  // Pending stage (p1) and architectural commit (p2)
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_flags_p1 <= '0;
      pend_vld_p1   <= 1'b0;
      arch_flags_p2 <= '0;
      cnt_p2        <= '0;
    end else if (!freeze) begin
      if (capture_p0) begin
        pend_flags_p1 <= flags_p0;
        pend_vld_p1   <= 1'b1;
      end else begin
        pend_vld_p1   <= 1'b0;
      end
      if (pend_vld_p1) begin
        arch_flags_p2 <= pend_flags_p1;
        cnt_p2        <= sat_inc(cnt_p2);
      end
    end
  end

  assign commit_cnt = cnt_p2;

`ifdef STAT_BYPASS_EN
  assign stat_out      = latest;
  assign flags_pending = 1'b0;
`else
  assign stat_out      = arch_flags_p2;
  assign flags_pending = pend_vld_p1;
`endif

endmodule

// File: tb/tb_status_reg_writer.sv
// Scoreboard bench for status_reg_writer: a queue-based flag model predicts each cycle's outputs.
`ifndef STATUS_REG_LEN
`define STATUS_REG_LEN 4
`endif

module tb_status_reg_writer;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, exe_valid, s_bit, flag_arith;
  logic [31:0] alu_res;
  logic        alu_cout, alu_ovf;
  logic [`STATUS_REG_LEN-1:0] stat_out;
  logic        flags_pending;
  logic [7:0]  commit_cnt;

  status_reg_writer #(.DATA_W(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .exe_valid(exe_valid), .s_bit(s_bit), .flag_arith(flag_arith),
    .alu_res(alu_res), .alu_cout(alu_cout), .alu_ovf(alu_ovf),
    .stat_out(stat_out), .flags_pending(flags_pending), .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: committed flags, list of writes in flight, commit count
  logic [3:0] m_arch;
  logic [3:0] m_inflight[$];
  int         m_cnt;
  logic [12:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic step(input logic r, input logic frz, input logic fl, input logic v,
                      input logic s, input logic ar, input logic [31:0] res,
                      input logic co, input logic ov);
    logic [3:0] lat, nf, exp_stat;
    logic       exp_pend;
    rst = r; freeze = frz; flush = fl; exe_valid = v; s_bit = s; flag_arith = ar;
    alu_res = res; alu_cout = co; alu_ovf = ov;
    if (r) begin
      m_arch = 4'b0000;
      m_inflight.delete();
      m_cnt = 0;
    end else if (!frz) begin
      lat = (m_inflight.size() != 0) ? m_inflight[0] : m_arch;
      // {Z,C,N,V}
      nf = {res == 32'd0, ar ? co : lat[2], res[31], ar ? ov : lat[0]};
      if (m_inflight.size() != 0) begin
        m_arch = m_inflight.pop_front();
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
      if (v && s && !fl) m_inflight.push_back(nf);
    end
`ifdef STAT_BYPASS_EN
    exp_stat = (m_inflight.size() != 0) ? m_inflight[0] : m_arch;
    exp_pend = 1'b0;
`else
    exp_stat = m_arch;
    exp_pend = (m_inflight.size() != 0);
`endif
    exp_q.push_back({exp_stat, exp_pend, 8'(m_cnt)});
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom, 1'b0, 1'b0);
  endtask

  // Monitor: one expectation per clock edge, sampled 1 time unit after the edge
  initial begin
    logic [12:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = {stat_out, flags_pending, commit_cnt};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs cycle %0d: got stat=%b pend=%b cnt=%0d, expected stat=%b pend=%b cnt=%0d",
                   cyc, a[12:9], a[8], a[7:0], e[12:9], e[8], e[7:0]);
        end
      end
    end
  end

  initial begin
    logic [31:0] r;
    #2;
    // Reset with random inputs
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom, 1'($urandom), 1'($urandom));
    idle();
    // Z/C latency
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0, 1'b1, 1'b0);
    idle();
    idle();
    // C/V preserve across back-to-back writes
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd5, 1'b1, 1'b0);
    idle();
    idle();
    // Flushed S-bit op is dropped; a flush does not cancel an existing pending write
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'd0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_0000, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0);
    idle();
    // Freeze for 3 cycles while a write is pending, with and without flush
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd7, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'd9, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    idle();
    idle();
    // Saturation
    for (int i = 0; i < 300; i++)
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
    idle();
    idle();
    // Reset mid-operation
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd3, 1'b1, 1'b1);
    idle();
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      case ($urandom_range(0, 3))
        0: r = 32'd0;
        1: r[31] = 1'b1;
        default: ;
      endcase
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 5) != 0), ($urandom_range(0, 3) != 0), 1'($urandom), r,
           1'($urandom), 1'($urandom));
    end
    idle();
    @(posedge clk);
    #3;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
